// File: rtl/camera_config_seq.sv
// Walks a fixed OV7670 register table and hands each {regis, value} write to the
// SCCB sender over the send/taken handshake, with table-driven delays and a watchdog.
module camera_config_seq #(
  parameter logic [7:0]  CAM_ID     = 8'h42,
  parameter int unsigned DELAY_UNIT = 500000,
  parameter int unsigned TIMEOUT    = 65536,
  parameter bit          AUTO_START = 1'b1,
  parameter logic [7:0]  DELAY_VAL  = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       taken,
  output logic       send,
  output logic [7:0] id,
  output logic [7:0] regis,
  output logic [7:0] value,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [4:0] index
);

  typedef enum logic [2:0] {IDLE, FETCH, SEND, DELAY, DONE} state_t;

  state_t      state;
  logic        start_q;
  logic        auto_go;
  logic [31:0] count;
  logic [31:0] wdog;
  logic [15:0] entry;
  logic        start_edge;
  logic        is_end;
  logic        is_delay;
  logic [4:0]  index_inc;
  logic [31:0] delay_cycles;

  always_comb begin
    entry = 16'hFFFF;
    case (index)
      5'd0: entry = 16'h1280;
      5'd1: entry = {8'hFE, DELAY_VAL};
      5'd2: entry = 16'h1204;
      5'd3: entry = 16'h1100;
      5'd4: entry = 16'h0C00;
      5'd5: entry = 16'h3E00;
      5'd6: entry = 16'h40D0;
      5'd7: entry = 16'h8C00;
      default: entry = 16'hFFFF;
    endcase
  end

  assign start_edge   = start & ~start_q;
  assign is_end       = (entry == 16'hFFFF);
  assign is_delay     = (entry[15:8] == 8'hFE) && !is_end;
  assign index_inc    = (index == 5'd31) ? index : index + 5'd1;
  assign delay_cycles = 32'(entry[7:0]) * DELAY_UNIT - 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      auto_go <= AUTO_START;
      count   <= '0;
      wdog    <= '0;
      send    <= 1'b0;
      id      <= CAM_ID;
      regis   <= '0;
      value   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      index   <= '0;
    end else begin
      start_q <= start;
      id      <= CAM_ID;
      case (state)
        IDLE, DONE: begin
          // auto_go only survives the first cycle after reset release
          if (start_edge || auto_go) begin
            auto_go <= 1'b0;
            state   <= FETCH;
            index   <= '0;
            error   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        FETCH: begin
          if (is_end) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (is_delay) begin
            if (entry[7:0] == 8'd0) begin
              index <= index_inc;
            end else begin
              state <= DELAY;
              count <= delay_cycles;
            end
          end else begin
            state <= SEND;
            regis <= entry[15:8];
            value <= entry[7:0];
            send  <= 1'b1;
            wdog  <= '0;
          end
        end
        SEND: begin
          if (taken) begin
            send  <= 1'b0;
            index <= index_inc;
            state <= FETCH;
          end else if (wdog == TIMEOUT - 1) begin
            send  <= 1'b0;
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        DELAY: begin
          if (count == '0) begin
            index <= index_inc;
            state <= FETCH;
          end else begin
            count <= count - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_config_seq.sv
// Directed bench for camera_config_seq: full table run, handshake latency,
// mid-delay start, rerun from DONE, watchdog timeout, zero delay skip, async reset.
module tb_camera_config_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // DUT A: auto start, sender model
  logic rst_a, start_a, taken_a, send_a, busy_a, done_a, error_a;
  logic [7:0] id_a, regis_a, value_a;
  logic [4:0] index_a;
  camera_config_seq #(.CAM_ID(8'h42), .DELAY_UNIT(10000), .TIMEOUT(65536), .AUTO_START(1'b1))
    u_a (.clk(clk), .rst_n(rst_a), .start(start_a), .taken(taken_a), .send(send_a), .id(id_a),
         .regis(regis_a), .value(value_a), .busy(busy_a), .done(done_a), .error(error_a),
         .index(index_a));

  // DUT T: manual start, short watchdog, taken never arrives
  logic rst_n, start_t, taken_t, send_t, busy_t, done_t, error_t;
  logic [7:0] id_t, regis_t, value_t;
  logic [4:0] index_t;
  camera_config_seq #(.CAM_ID(8'h42), .DELAY_UNIT(10000), .TIMEOUT(100), .AUTO_START(1'b0))
    u_t (.clk(clk), .rst_n(rst_n), .start(start_t), .taken(taken_t), .send(send_t), .id(id_t),
         .regis(regis_t), .value(value_t), .busy(busy_t), .done(done_t), .error(error_t),
         .index(index_t));

  // DUT S: table built with a zero-length delay marker
  logic start_s, taken_s, send_s, busy_s, done_s, error_s;
  logic [7:0] id_s, regis_s, value_s;
  logic [4:0] index_s;
  camera_config_seq #(.CAM_ID(8'h42), .DELAY_UNIT(10000), .TIMEOUT(1000), .AUTO_START(1'b0),
                      .DELAY_VAL(8'h00))
    u_s (.clk(clk), .rst_n(rst_n), .start(start_s), .taken(taken_s), .send(send_s), .id(id_s),
         .regis(regis_s), .value(value_s), .busy(busy_s), .done(done_s), .error(error_s),
         .index(index_s));

  // Sender model: taken one cycle after send is seen, then busy for 64 cycles
  initial begin
    taken_a = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (send_a) begin
        @(posedge clk); #1 taken_a = 1'b1;
        @(posedge clk); #1 taken_a = 1'b0;
        repeat (64) @(posedge clk);
      end
    end
  end

  // regis/value must not move while send stays high
  logic       prev_send = 1'b0;
  logic [7:0] prev_r = '0, prev_v = '0;
  int         stable_viol = 0;
  always @(negedge clk) begin
    if (send_a && prev_send && (regis_a != prev_r || value_a != prev_v))
      stable_viol <= stable_viol + 1;
    prev_send <= send_a;
    prev_r    <= regis_a;
    prev_v    <= value_a;
  end

  typedef struct {
    logic [7:0] r;
    logic [7:0] v;
    int         lat;
    bit         last;
  } wr_t;
  wr_t tbl[7];

  initial begin
    int n;
    int hi;
    tbl[0] = '{8'h12, 8'h80, 10003, 1'b0};
    tbl[1] = '{8'h12, 8'h04, 2, 1'b0};
    tbl[2] = '{8'h11, 8'h00, 2, 1'b0};
    tbl[3] = '{8'h0C, 8'h00, 2, 1'b0};
    tbl[4] = '{8'h3E, 8'h00, 2, 1'b0};
    tbl[5] = '{8'h40, 8'hD0, 2, 1'b0};
    tbl[6] = '{8'h8C, 8'h00, 2, 1'b1};

    rst_a = 1'b0; rst_n = 1'b0;
    start_a = 1'b0; start_t = 1'b0; start_s = 1'b0;
    taken_t = 1'b0; taken_s = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_send", send_a, 0);
    check("rst_regis", regis_a, 0);
    check("rst_value", value_a, 0);
    check("rst_index", index_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_error", error_a, 0);
    check("rst_id", id_a, 8'h42);
    rst_a = 1'b1; rst_n = 1'b1;

    // Run 1: auto start, walk the whole table
    for (int i = 0; i < 7; i++) begin
      n = 0;
      while (!send_a && n < 30000) begin @(negedge clk); n++; end
      check("send_seen", send_a, 1);
      check("wr_regis", regis_a, tbl[i].r);
      check("wr_value", value_a, tbl[i].v);
      n = 0;
      while (!taken_a && n < 200) begin @(negedge clk); n++; end
      check("taken_seen", taken_a, 1);
      n = 0;
      do begin
        @(negedge clk); n++;
        if (n == 1) check("send_drop", send_a, 0);
      end while (!(send_a || done_a) && n < 20000);
      check("latency", n, tbl[i].lat);
      if (tbl[i].last) check("end_done", done_a, 1);
      else check("next_send", send_a, 1);
    end
    check("run1_done", done_a, 1);
    check("run1_busy", busy_a, 0);
    check("run1_index", index_a, 8);
    check("run1_error", error_a, 0);
    repeat (100) @(negedge clk);

    // Run 2: start from DONE, completion time from the start edge
    start_a = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin
        start_a = 1'b0;
        check("rerun_done_clr", done_a, 0);
        check("rerun_busy", busy_a, 1);
        check("rerun_index", index_a, 0);
        check("rerun_error", error_a, 0);
      end
    end while (!done_a && n < 20000);
    check("run2_cycles", n, 10344);
    repeat (100) @(negedge clk);

    // Run 3: start pulse in the middle of DELAY must not change anything
    start_a = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) start_a = 1'b0;
      if (n == 3000) begin
        start_a = 1'b1;
        check("mid_delay_busy", busy_a, 1);
      end
      if (n == 3001) start_a = 1'b0;
    end while (!done_a && n < 20000);
    check("run3_cycles", n, 10344);
    check("run3_index", index_a, 8);
    check("stable_while_send", stable_viol, 0);

    // Watchdog: no auto start, then no taken
    check("noauto_busy", busy_t, 0);
    check("noauto_send", send_t, 0);
    check("noauto_done", done_t, 0);
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    n = 0; hi = 0;
    while (!done_t && n < 400) begin
      @(negedge clk); n++;
      if (send_t) hi++;
    end
    check("to_send_cycles", hi, 100);
    check("to_error", error_t, 1);
    check("to_done", done_t, 1);
    check("to_busy", busy_t, 0);
    check("to_send", send_t, 0);
    check("to_index", index_t, 0);
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    check("to_err_clr", error_t, 0);
    check("to_done_clr", done_t, 0);
    check("to_rerun_busy", busy_t, 1);

    // Zero-length delay marker is skipped without a DELAY interval
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    n = 0;
    while (!send_s && n < 20) begin @(negedge clk); n++; end
    check("skip_first_regis", regis_s, 8'h12);
    taken_s = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) taken_s = 1'b0;
      if (n == 2) check("skip_index", index_s, 2);
    end while (!send_s && n < 50);
    check("skip_latency", n, 3);
    check("skip_regis", regis_s, 8'h12);
    check("skip_value", value_s, 8'h04);

    // Asynchronous reset in the middle of a SEND
    repeat (100) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (!(send_a && index_a == 5'd3) && n < 20000) begin @(negedge clk); n++; end
    check("ar_reach_send", send_a, 1);
    #2 rst_a = 1'b0;
    #1;
    check("ar_send", send_a, 0);
    check("ar_busy", busy_a, 0);
    check("ar_index", index_a, 0);
    @(negedge clk);
    rst_a = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/camera_config_seq.md
# camera_config_seq

Sequencer that walks a fixed table of OV7670 register writes and hands each write to the SCCB `sender` block, one `{regis, value}` pair per transaction, using the `send`/`taken` handshake. It sits between system reset/start logic and `sender`. It inserts programmable delays at table-marked points, such as after the soft-reset write, and reports completion or a handshake timeout.

## Interface
- `CAM_ID`, 8'h42: SCCB write address driven on `id`.
- `DELAY_UNIT`, 500000: cycles per delay unit (10 ms at 50 MHz). Must be ≥ 8192, so one unit outlasts a `sender` frame.
- `TIMEOUT`, 65536: maximum cycles in SEND without `taken` before the error exit.
- `AUTO_START`, 1: if 1, a configuration run starts automatically after reset release.

- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: rising-edge request to (re)run the table. Honoured only in IDLE or DONE.
- `taken` in 1: one-cycle pulse from `sender`; the current write has been latched.
- `send` out 1: write request to `sender`.
- `id` out 8: constant `CAM_ID`.
- `regis` out 8: register address of the current write.
- `value` out 8: data of the current write.
- `busy` out 1: high from run start until DONE is reached.
- `done` out 1: high in DONE and held until the next start or reset.
- `error` out 1: set on timeout; cleared at the next start.
- `index` out 5: current table index (debug).

## Operation
- Table: combinational ROM of 16-bit entries `{reg, val}`, indexed by `index`.
  - 0: {12,80} soft reset
  - 1: {FE,01} delay marker
  - 2: {12,04} RGB output
  - 3: {11,00}
  - 4: {0C,00}
  - 5: {3E,00}
  - 6: {40,D0} RGB565, full range
  - 7: {8C,00}
  - 8: {FF,FF} end marker
  - Indices 9–31 read as FFFF.
- Entry decode:
  - `reg`=FE (and entry ≠ FFFF) is a delay of `val`×`DELAY_UNIT` cycles.
  - Entry FFFF is end of table.
  - Anything else is a register write.
- States: IDLE, FETCH, SEND, DELAY, DONE.
- IDLE → FETCH on a `start` rising edge, or on the first cycle after reset release when `AUTO_START`=1. On entry to FETCH:
  - `index` is cleared to 0.
  - `error` and `done` are cleared.
  - `busy` is set.
- FETCH (1 cycle) decodes `table[index]`:
  - End marker → DONE.
  - Delay marker with `val`=0 → `index`+1, then FETCH.
  - Delay marker with `val`>0 → DELAY; load the counter with `val`×`DELAY_UNIT`−1 (32-bit, no overflow for `val`≤255).
  - Write → SEND; register `regis`=`reg`, `value`=`val`, `send`=1, clear the watchdog.
- SEND:
  - Hold `send`, `regis` and `value` stable.
  - On `taken`: `send`←0, `index`+1, go to FETCH.
  - If the watchdog reaches `TIMEOUT`−1 without `taken`: `send`←0, `error`←1, go to DONE.
- DELAY: decrement the counter each cycle. At 0: `index`+1, go to FETCH.
- DONE: `busy`=0, `done`=1. A `start` rising edge goes to FETCH, same as from IDLE.
- `index` saturates at 31 and never wraps.
- `start` edges in FETCH, SEND or DELAY are ignored and not queued.

## Timing
- Reset values:
  - `send`=0, `regis`=0, `value`=0, `index`=0.
  - `busy`=0, `done`=0, `error`=0.
  - `id`=`CAM_ID`.
  - State = IDLE.
- Reset is asynchronous. Assertion mid-run (any state) immediately forces the reset values. An in-flight `sender` frame is not the sequencer's concern.
- All outputs are registered.
- `start` edge detect: `start` is registered. An edge in cycle N enters FETCH in N+1 and `send` rises in N+2.
- `taken` in cycle N:
  - `send`=0 in N+1.
  - Next FETCH in N+1; the next `send` rises in N+2.
  - `sender` is still busy then, so it latches the next write only after its current frame.
- `send` and `taken` high in the same cycle as a state change is impossible: `taken` is only acted on in SEND.
- A delay of k units occupies exactly k×`DELAY_UNIT` cycles in DELAY. The delay counts from the entry to DELAY, which follows the preceding `taken`.

## Test plan
- Reset with `AUTO_START`=1 and a `sender` model that pulses `taken` 2 cycles after `send` and then stays busy 8192 cycles, `DELAY_UNIT`=10000 → writes (12,80), a 10000-cycle gap, then (12,04),(11,00),(0C,00),(3E,00),(40,D0),(8C,00). Afterwards `done`=1, `busy`=0, `index`=8, `error`=0.
- `taken` pulse in cycle N → `send`=0 at N+1 and `send`=1 with the next `regis` at N+2; `regis`/`value` are never changed while `send`=1.
- `taken` held low, `TIMEOUT`=100 → `send` drops after exactly 100 SEND cycles, `error`=1, `done`=1, `index` unchanged.
- Mid-DELAY `start` pulse → ignored (same completion cycle count). `start` pulse in DONE → rerun from index 0 with `error`/`done` cleared.
- `rst_n` asserted asynchronously mid-SEND → `send`, `busy` and `index` are 0 before the next clock edge. With `AUTO_START`=0 the block stays in IDLE until `start`.
- Force a table entry {FE,00} (alternate ROM build) → skipped in 2 cycles with no DELAY state entered.
